// File: rtl/alu_decode_stage.sv
// Decodes RV32I OP / OP-IMM / LUI instructions into ALU control, operands and write-back info.
// Latency: 1 cycle from accept to out_valid, through a single registered output entry.
// Backpressure: in_ready = !out_valid || out_ready; a held result stays frozen until consumed.
module alu_decode_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] bus_A,
    output logic [DATA_WIDTH-1:0] bus_B,
    output logic [4:0]            rd_addr,
    output logic                  rd_we,
    output logic                  illegal,
    output logic [15:0]           decoded_cnt,
    output logic [15:0]           illegal_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Decoded view of the current input instruction.
    typedef struct packed {
        logic [3:0]            ctrl;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [4:0]            rd;
        logic                  we;
        logic                  ill;
    } dec_t;

    // funct3 to upper three ALU code bits; only OR/AND swap places relative to funct3.
    function automatic logic [2:0] f3_map(input logic [2:0] f3);
        logic [2:0] m;
        case (f3)
            3'b110:  m = 3'b111;
            3'b111:  m = 3'b110;
            default: m = f3;
        endcase
        return m;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shift_imm;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

    dec_t                  dec;
    logic                  legal;
    logic [3:0]            code;
    logic [DATA_WIDTH-1:0] opnd1;
    logic [DATA_WIDTH-1:0] opnd2;
    logic                  swap_ops;

    // Combinational instruction decode and operand selection.
    always_comb begin
        legal = 1'b0;
        code  = 4'b0000;
        opnd1 = rs1_data;
        opnd2 = '0;
        case (opcode)
            OPC_OP: begin
                code  = {f3_map(funct3), instr[30]};
                opnd2 = rs2_data;
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                // Only SRAI carries the alternate bit; ADDI has no subtract form.
                code  = {f3_map(funct3), (funct3 == 3'b101) && (funct7 == F7_ALT)};
                opnd2 = shift_imm ? DATA_WIDTH'(instr[24:20])
                                  : DATA_WIDTH'($signed(instr[31:20]));
                case (funct3)
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                code  = 4'b0000;
                opnd1 = '0;
                opnd2 = DATA_WIDTH'({instr[31:12], 12'b0});
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // SUB and the shifts take the register value on bus_B.
        swap_ops = (code == ALU_SUB) || (code == ALU_SLL) ||
                   (code == ALU_SRL) || (code == ALU_SRA);

        dec.rd = instr[11:7];
        if (legal) begin
            dec.ctrl = code;
            dec.a    = swap_ops ? opnd2 : opnd1;
            dec.b    = swap_ops ? opnd1 : opnd2;
            dec.we   = (instr[11:7] != 5'd0);
            dec.ill  = 1'b0;
        end else begin
            dec.ctrl = 4'b0000;
            dec.a    = '0;
            dec.b    = '0;
            dec.we   = 1'b0;
            dec.ill  = 1'b1;
        end
    end

    logic                  out_valid_q, out_valid_d;
    dec_t                  out_q, out_d;
    logic [15:0]           decoded_cnt_q, decoded_cnt_d;
    logic [15:0]           illegal_cnt_q, illegal_cnt_d;
    logic                  accept;

    assign in_ready = !out_valid_q || out_ready;
    // Flush wins over any simultaneous accept.
    assign accept   = in_valid && in_ready && !flush;

    // Next-state for the output entry and the saturating event counters.
    always_comb begin
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        decoded_cnt_d = decoded_cnt_q;
        illegal_cnt_d = illegal_cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec;
            if (!dec.ill && (decoded_cnt_q != CNT_MAX)) begin
                decoded_cnt_d = decoded_cnt_q + 16'd1;
            end
            if (dec.ill && (illegal_cnt_q != CNT_MAX)) begin
                illegal_cnt_d = illegal_cnt_q + 16'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and counters; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_q         <= '0;
            decoded_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_q         <= out_d;
            decoded_cnt_q <= decoded_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_ctrl    = out_q.ctrl;
    assign bus_A       = out_q.a;
    assign bus_B       = out_q.b;
    assign rd_addr     = out_q.rd;
    assign rd_we       = out_q.we;
    assign illegal     = out_q.ill;
    assign decoded_cnt = decoded_cnt_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] bus_A;
    logic [31:0] bus_B;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
    logic [15:0] decoded_cnt;
    logic [15:0] illegal_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .bus_A       (bus_A),
        .bus_B       (bus_B),
        .rd_addr     (rd_addr),
        .rd_we       (rd_we),
        .illegal     (illegal),
        .decoded_cnt (decoded_cnt),
        .illegal_cnt (illegal_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then land just after the rising edge.
    task automatic cyc(input logic vld, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = vld;
        instr     = ins;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic we,
                           input logic ill);
        chk({tag, ".out_valid"}, out_valid, 1'b1);
        chk({tag, ".alu_ctrl"}, alu_ctrl, ctrl);
        chk({tag, ".bus_A"}, bus_A, a);
        chk({tag, ".bus_B"}, bus_B, b);
        chk({tag, ".rd_addr"}, rd_addr, rd);
        chk({tag, ".rd_we"}, rd_we, we);
        chk({tag, ".illegal"}, illegal, ill);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.alu_ctrl", alu_ctrl, 4'h0);
        chk("rst.bus_A", bus_A, 32'h0);
        chk("rst.decoded_cnt", decoded_cnt, 16'h0);
        chk("rst.illegal_cnt", illegal_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SUB x3,x1,x2: register operand swaps onto bus_B
        cyc(1'b1, 32'h402081B3, 32'd10, 32'd3, 1'b1, 1'b0);
        chk_out("sub", 4'b0001, 32'd3, 32'd10, 5'd3, 1'b1, 1'b0);
        chk("sub.decoded_cnt", decoded_cnt, 16'd1);

        // ADDI x5,x0,-1
        cyc(1'b1, 32'hFFF00293, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_out("addi", 4'b0000, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0);

        // SRAI x1,x1,4
        cyc(1'b1, 32'h4040D093, 32'h80000000, 32'h0, 1'b1, 1'b0);
        chk_out("srai", 4'b1011, 32'd4, 32'h80000000, 5'd1, 1'b1, 1'b0);
        chk("srai.decoded_cnt", decoded_cnt, 16'd3);

        // Backpressure: OR x4,x1,x2 offered while SRAI result is held
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h0020E233, 32'h0F0F0000, 32'h000000FF, 1'b0, 1'b0);
            chk("bp.in_ready", in_ready, 1'b0);
            chk("bp.alu_ctrl", alu_ctrl, 4'b1011);
            chk("bp.bus_B", bus_B, 32'h80000000);
            chk("bp.out_valid", out_valid, 1'b1);
        end
        chk("bp.decoded_cnt", decoded_cnt, 16'd3);
        cyc(1'b1, 32'h0020E233, 32'h0F0F0000, 32'h000000FF, 1'b1, 1'b0);
        chk_out("or", 4'b1110, 32'h0F0F0000, 32'h000000FF, 5'd4, 1'b1, 1'b0);
        chk("or.decoded_cnt", decoded_cnt, 16'd4);
        cyc(1'b0, 32'h0020E233, 32'h0F0F0000, 32'h000000FF, 1'b1, 1'b0);
        chk("or.drain_valid", out_valid, 1'b0);
        chk("or.single_accept", decoded_cnt, 16'd4);

        // LUI x7,0x12345: rs1 value ignored
        cyc(1'b1, 32'h123453B7, 32'h0000DEAD, 32'h0000BEEF, 1'b1, 1'b0);
        chk_out("lui", 4'b0000, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0);

        // OP with funct7 0100000 and funct3 001 is illegal
        cyc(1'b1, 32'h40209233, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
        chk_out("badf7", 4'b0000, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1);
        chk("badf7.illegal_cnt", illegal_cnt, 16'd1);

        // ADD x0,x1,x2: legal but no write-back
        cyc(1'b1, 32'h00208033, 32'd5, 32'd6, 1'b1, 1'b0);
        chk_out("addx0", 4'b0000, 32'd5, 32'd6, 5'd0, 1'b0, 1'b0);
        chk("addx0.decoded_cnt", decoded_cnt, 16'd6);

        // JAL is illegal here
        cyc(1'b1, 32'h0000006F, 32'd1, 32'd2, 1'b1, 1'b0);
        chk_out("jal", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("jal.illegal_cnt", illegal_cnt, 16'd2);

        // Flush together with an accept
        cyc(1'b1, 32'h00208033, 32'd5, 32'd6, 1'b1, 1'b1);
        chk("flush.out_valid", out_valid, 1'b0);
        chk("flush.decoded_cnt", decoded_cnt, 16'd6);
        chk("flush.illegal_cnt", illegal_cnt, 16'd2);

        // Saturation: fresh reset, then 65535 back-to-back accepts
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("sat.cnt_reset", decoded_cnt, 16'h0);
        in_valid  = 1'b1;
        instr     = 32'hFFF00293;
        rs1_data  = 32'h0;
        out_ready = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("sat.at_max", decoded_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("sat.hold_max", decoded_cnt, 16'hFFFF);
        chk("sat.illegal_cnt", illegal_cnt, 16'h0);

        // Asynchronous reset in the middle of a stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 1'b0);
        chk("arst.alu_ctrl", alu_ctrl, 4'h0);
        chk("arst.bus_A", bus_A, 32'h0);
        chk("arst.bus_B", bus_B, 32'h0);
        chk("arst.rd_addr", rd_addr, 5'h0);
        chk("arst.rd_we", rd_we, 1'b0);
        chk("arst.illegal", illegal, 1'b0);
        chk("arst.decoded_cnt", decoded_cnt, 16'h0);
        chk("arst.illegal_cnt", illegal_cnt, 16'h0);
        chk("arst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.dropped", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
